// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, round constants and the
// scheduler state encoding.
package aes_pkg;

  localparam int AES_NR        = 10;
  localparam int AES_KW        = 128;
  localparam int AES_RK_BANK_W = AES_KW * (AES_NR + 1);

  // Rcon[1..10] stored at index 0..9.
  localparam logic [7:0] AES_RCON [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } aes_state_e;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round_key_scheduler_if.sv
// Request/result bundle of the round-key scheduler. The scheduler is the slave.
//
// Handshake: start is a one-cycle request that is accepted only on an edge
// where the scheduler is idle and reset is low; there is no back-pressure, so
// a start seen while busy is dropped. round_keys is meaningful only while
// keys_valid is high; done marks the single cycle in which it became valid.
interface aes_round_key_scheduler_if;
  import aes_pkg::*;

  logic                     start;
  logic [0:AES_KW-1]        key;
  logic                     busy;
  logic                     done;
  logic                     keys_valid;
  logic [0:AES_RK_BANK_W-1] round_keys;
  aes_state_e               state_dbg;
  logic [3:0]               round_dbg;

  modport master (
    output start, key,
    input  busy, done, keys_valid, round_keys, state_dbg, round_dbg
  );

  modport slave (
    input  start, key,
    output busy, done, keys_valid, round_keys, state_dbg, round_dbg
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_round_key_scheduler.sv
// Iterative AES-128 key expansion: one round key per cycle into an 11-slot bank
// stored in decryption order (slot 0 = round key 10, slot 10 = cipher key).
module aes_round_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic                      clk,
  input  logic                      reset,
  aes_round_key_scheduler_if.slave  bus
);

  aes_state_e    state;
  aes_state_e    state_next;
  logic [3:0]    round;
  logic [3:0]    slot;
  logic [KW-1:0] work;
  logic [KW-1:0] bank [NR+1];
  logic [KW-1:0] next_key;
  logic [31:0]   rot;
  logic [31:0]   sub;
  logic [31:0]   t;
  logic [31:0]   n0, n1, n2, n3;
  logic [7:0]    rcon;
  logic          accept;
  logic          last;

  assign accept = (state == ST_IDLE) && bus.start;
  assign last   = (state == ST_EXPAND) && (round == 4'(NR));
  assign slot   = 4'(NR) - round;

  // SubWord(RotWord(w3)) with w3 the least-significant word of the working key.
  assign rot = rot_word(work[31:0]);
  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot[8*i +: 8]),
      .out_byte (sub[8*i +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    if (round != 4'd0 && round <= 4'(NR)) rcon = AES_RCON[round - 4'd1];
  end

  assign t        = sub ^ {rcon, 24'h000000};
  assign n0       = work[127:96] ^ t;
  assign n1       = work[95:64]  ^ n0;
  assign n2       = work[63:32]  ^ n1;
  assign n3       = work[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.start) state_next = ST_EXPAND;
      ST_EXPAND: if (last)      state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      round          <= 4'd0;
      work           <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.keys_valid <= 1'b0;
      for (int s = 0; s <= NR; s++) bank[s] <= '0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next == ST_EXPAND);
      bus.done <= last;
      if (accept) begin
        bank[NR]       <= bus.key;
        work           <= bus.key;
        round          <= 4'd1;
        bus.keys_valid <= 1'b0;
      end else if (state == ST_EXPAND) begin
        bank[slot] <= next_key;
        work       <= next_key;
        round      <= round + 4'd1;
        if (last) bus.keys_valid <= 1'b1;
      end
    end
  end

  // The bank is all registers; this only flattens it onto the output bus.
  for (genvar s = 0; s <= NR; s++) begin : g_flat
    assign bus.round_keys[KW*s +: KW] = bank[s];
  end

  assign bus.state_dbg = state;
  assign bus.round_dbg = round;

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// Bench for aes_round_key_scheduler: directed FIPS-197 vectors plus random keys
// against a word-array key-expansion model with a field-arithmetic S-box.
module tb_aes_round_key_scheduler;
  import aes_pkg::*;

  localparam int BANK_W = AES_RK_BANK_W;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_ZERO  = 128'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_key_scheduler_if bus ();

  aes_round_key_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [7:0]      sbox_ref [256];
  logic [BANK_W-1:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [BANK_W-1:0] ref_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [BANK_W-1:0] b;
    b  = '0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      b[BANK_W-1-128*(10-r) -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return b;
  endfunction

  function automatic logic [127:0] slot_of(input logic [BANK_W-1:0] b, input int s);
    return b[BANK_W-1-128*s -: 128];
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  bus.busy, 1'b0);
    check({tag, "_done"},  bus.done, 1'b0);
    check({tag, "_valid"}, bus.keys_valid, 1'b0);
    check({tag, "_state"}, bus.state_dbg, ST_IDLE);
    for (int s = 0; s <= 10; s++)
      check($sformatf("%s_slot%0d_zero", tag, s), slot_of(bus.round_keys, s), 128'h0);
  endtask

  task automatic issue_start(input string tag, input logic [127:0] k);
    bus.start = 1'b1;
    bus.key   = k;
    step();
    bus.start = 1'b0;
    bus.key   = rand_key();
    exp_q.push_back(ref_expand(k));
    check({tag, "_busy_e0"},  bus.busy, 1'b1);
    check({tag, "_valid_e0"}, bus.keys_valid, 1'b0);
    check({tag, "_slot10_e0"}, slot_of(bus.round_keys, 10), k);
  endtask

  task automatic check_bank(input string tag);
    logic [BANK_W-1:0] exp_bank;
    exp_bank = exp_q.pop_front();
    for (int s = 0; s <= 10; s++)
      check($sformatf("%s_slot%0d", tag, s), slot_of(bus.round_keys, s), slot_of(exp_bank, s));
  endtask

  // Waits for done (bounded). With noise set, competing starts with other keys
  // are driven on cycles 3 and 7; the key bus is scrambled every cycle.
  task automatic wait_done(input string tag, input bit noise);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      n++;
      bus.start = noise && (n == 3 || n == 7);
      bus.key   = rand_key();
      step();
      if (bus.done) seen = 1'b1;
      else check($sformatf("%s_busy_c%0d", tag, n), bus.busy, 1'b1);
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'd10);
    if (seen) begin
      check({tag, "_busy_done"},  bus.busy, 1'b0);
      check({tag, "_valid_done"}, bus.keys_valid, 1'b1);
      check_bank(tag);
    end
  endtask

  task automatic check_after_done(input string tag);
    step();
    check({tag, "_done_drop"},  bus.done, 1'b0);
    check({tag, "_valid_hold"}, bus.keys_valid, 1'b1);
    check({tag, "_busy_idle"},  bus.busy, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.key   = '0;
    reset     = 1'b1;
    build_sbox();
    repeat (3) step();
    check_cleared("reset");
    reset = 1'b0;
    step();
    check_cleared("post_reset_idle");

    // FIPS-197 example key
    issue_start("fips", K_FIPS);
    wait_done("fips", 1'b0);
    check("fips_slot9_vec",  slot_of(bus.round_keys, 9),  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_slot0_vec",  slot_of(bus.round_keys, 0),  128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_slot10_vec", slot_of(bus.round_keys, 10), K_FIPS);
    check_after_done("fips");

    // Sequential-byte key
    issue_start("seq", K_SEQ);
    wait_done("seq", 1'b0);
    check("seq_slot0_vec", slot_of(bus.round_keys, 0), 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("seq_slot9_vec", slot_of(bus.round_keys, 9), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check_after_done("seq");

    // Starts while busy are ignored; exactly one done
    issue_start("noise", K_FIPS);
    wait_done("noise", 1'b1);
    check("noise_slot0_vec", slot_of(bus.round_keys, 0), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("noise_no_second_done%0d", i), bus.done, 1'b0);
    end

    // Reset mid-expansion with start held: reset wins, bank cleared
    issue_start("abort", rand_key());
    repeat (4) step();
    check("abort_round5", bus.round_dbg, 4'd5);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.key   = K_SEQ;
    step();
    void'(exp_q.pop_back());
    check_cleared("abort");
    reset     = 1'b0;
    bus.start = 1'b0;
    step();
    check("abort_start_not_taken", bus.busy, 1'b0);
    issue_start("after_abort", K_FIPS);
    wait_done("after_abort", 1'b0);

    // Back-to-back: start accepted on the done cycle
    issue_start("b2b_first", K_FIPS);
    wait_done("b2b_first", 1'b0);
    issue_start("b2b_second", K_SEQ);
    wait_done("b2b_second", 1'b0);
    check("b2b_slot0_vec", slot_of(bus.round_keys, 0), 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_after_done("b2b");

    // All-zero key
    issue_start("zero", K_ZERO);
    wait_done("zero", 1'b0);
    check("zero_slot9_vec", slot_of(bus.round_keys, 9), 128'h62636363626363636263636362636363);
    check("zero_slot0_vec", slot_of(bus.round_keys, 0), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_after_done("zero");

    // Random keys with random idle gaps and random busy-time noise
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) step();
      issue_start($sformatf("rnd%0d", i), rand_key());
      wait_done($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
    end

    check("exp_q_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_key_scheduler.md
Name: aes_round_key_scheduler

Overview:
Iterative AES-128 key-expansion engine placed directly upstream of the decryption datapath.
- Accepts a 128-bit cipher key on a start pulse.
- Generates one round key per cycle: rounds 1..10, 10 cycles total.
- Stores all 11 round keys in a flat register bank in decryption order: slot 0 = round key 10, slot 10 = cipher key. The decrypt stage indexes the slots directly.
- Raises a done pulse and a level valid flag when the bank is complete.

Parameters:
NR, 10, number of AES-128 rounds (fixed; exposed for assertions only)
KW, 128, key/round-key width in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request expansion of key; sampled only in IDLE
key  input  128  cipher key, big-endian ([0:127], bit 0 = MSB of byte 0); sampled on the accepted start edge
busy  output  1  high while in EXPAND
done  output  1  one-cycle pulse when slot 0 (round key 10) is written
keys_valid  output  1  level; high from done until the next accepted start or reset
round_keys  output  1408  [0:1407]; slot s occupies bits [128*s : 128*s+127] and holds round key (10-s)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- On reset:
  - state = IDLE, round counter = 0.
  - busy = 0, done = 0, keys_valid = 0, round_keys = all zeros.
- States: IDLE, EXPAND.
- IDLE with start = 1 (accepted start edge E0):
  - Slot 10 ← key; working key ← key; round = 1; Rcon index = 0.
  - keys_valid ← 0, busy ← 1, state ← EXPAND.
- EXPAND, edge Er for r = 1..10:
  - Words w0..w3 of the working key; t = SubWord(RotWord(w3)) XOR {Rcon[r],00,00,00}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2. This is a combinational chain inside one cycle.
  - Slot (10-r) ← {n0,n1,n2,n3}; working key ← same; round ← r+1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- At edge E10 (r = 10): done ← 1, keys_valid ← 1, busy ← 0, state ← IDLE.
- done returns to 0 at the next edge.
- Latency: the start edge counts as E0; done and keys_valid are visible after edge E10, i.e. 10 cycles after start is sampled.
- Back-to-back operation: start during the done cycle is accepted (state is IDLE). keys_valid drops at that edge.
- start while busy: ignored. key changes during EXPAND have no effect.
- Reset during EXPAND: immediate abort to the reset values. The partially written bank is cleared to zero.
- Reset and start in the same cycle: reset wins; the start is not accepted.
- Slots not yet written in the current expansion hold stale values. Consumers must qualify round_keys with keys_valid.
- All outputs are registered. No combinational path from key or start to any output.

Decomposition:
- Package aes_pkg holds the shared definitions:
  - Constants AES_NR = 10, AES_KW = 128, AES_RK_BANK_W = 1408.
  - The Rcon table as a 10-entry byte constant.
  - The state encoding (IDLE, EXPAND).
- Sub-module aes_sbox: a combinational 8-bit forward S-box. Instantiate it 4 times to form SubWord. The encrypt path reuses the same module.
- Everything else (control, chain, bank) stays in this block: about 200–250 lines total.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - busy high for 10 cycles.
  - done pulses exactly 10 cycles after start.
  - slot 9 = a0fafe1788542cb123a339392a6c7605.
  - slot 0 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - slot 10 = the key.
- Key 000102030405060708090a0b0c0d0e0f:
  - slot 0 = 13111d7fe3944a17f307a78b4d2b30c5.
  - slot 9 = d6aa74fdd2af72fadaa678f1d6ab76fe.
- start pulsed again at cycles 3 and 7 of an expansion, with a different key on key: ignored; results identical to scenario 1; single done.
- reset asserted at EXPAND round 5, start held high simultaneously:
  - Next cycle: busy = 0, keys_valid = 0, round_keys = 0.
  - A later start produces the correct full bank.
- Back-to-back: start on the done cycle with key 000102...0f:
  - keys_valid drops the following cycle.
  - Second done is 10 cycles later.
  - Bank matches scenario 2.
- All-zero key:
  - slot 9 = 62636363626363636263636362636363.
  - slot 0 = b4ef5bcb3e92e21123e951cf6f8f188e.
